hazard_controller: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS core (IF/DEC/EX/MEM/WB).

---
 rtl/hazard_controller.sv | 147 ++++++++++++++
 tb/tb_hazard_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// hazard_controller
//   Stall/flush sequencer for the 5-stage core. It picks one hazard cause per
//   cycle in fixed priority and drives the per-stage stall and bubble controls
//   combinationally from that cycle's inputs. The cause served is recorded in
//   a state register. The block also keeps saturating stall/bubble counters
//   and a sticky watchdog that trips on long miss waits.
//
//   Ports
//     clk, rst          core clock; synchronous active-high reset
//     i_lw_hazard       load-use hazard (DEC vs EX load)
//     i_ic_miss         IF fetch not ready
//     i_dc_miss         MEM access not ready
//     i_mispredict      EX branch resolved against prediction
//     o_stall_if..mem   per-stage hold controls
//     o_flush_dec/ex    bubble inserts into IF->DEC / DEC->EX
//     o_state           cause served last cycle
//     o_stall_cycles    saturating count of cycles with o_stall_if=1
//     o_bubble_count    saturating count of cycles with any flush
//     o_timeout         sticky miss watchdog flag
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   RUN       | no hazard, pipeline advances
//   DC_WAIT   | D-cache miss, whole pipe frozen
//   REDIRECT  | mispredict, DEC and EX bubbled
//   LW_BUBBLE | load-use, IF/DEC held and a bubble goes into EX
//   IC_WAIT   | I-cache miss, IF held and a bubble goes into DEC

module hazard_controller #(
    parameter int CNT_WIDTH    = 32,
    parameter int MISS_TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_lw_hazard,
    input  logic                 i_ic_miss,
    input  logic                 i_dc_miss,
    input  logic                 i_mispredict,
    output logic                 o_stall_if,
    output logic                 o_stall_dec,
    output logic                 o_stall_ex,
    output logic                 o_stall_mem,
    output logic                 o_flush_dec,
    output logic                 o_flush_ex,
    output logic [2:0]           o_state,
    output logic [CNT_WIDTH-1:0] o_stall_cycles,
    output logic [CNT_WIDTH-1:0] o_bubble_count,
    output logic                 o_timeout
);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        DC_WAIT   = 3'd1,
        REDIRECT  = 3'd2,
        LW_BUBBLE = 3'd3,
        IC_WAIT   = 3'd4
    } state_t;

    localparam int WAIT_W = $clog2(MISS_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MISS_TIMEOUT - 1);

    state_t            cause;
    state_t            state_q;
    logic [WAIT_W-1:0] wait_left;
    logic              is_wait;

    always_comb begin
        cause = RUN;
        if (i_dc_miss)
            cause = DC_WAIT;
        else if (i_mispredict)
            cause = REDIRECT;
        else if (i_lw_hazard)
            cause = LW_BUBBLE;
        else if (i_ic_miss)
            cause = IC_WAIT;
    end

    assign is_wait = (cause == DC_WAIT) || (cause == IC_WAIT);

    // Zero-latency controls: DEC must see the load-use decision this cycle.
    // Reset forces bubbles into both front registers to drain the pipe.
    always_comb begin
        o_stall_if  = 1'b0;
        o_stall_dec = 1'b0;
        o_stall_ex  = 1'b0;
        o_stall_mem = 1'b0;
        o_flush_dec = 1'b0;
        o_flush_ex  = 1'b0;
        if (rst) begin
            o_flush_dec = 1'b1;
            o_flush_ex  = 1'b1;
        end else begin
            case (cause)
                DC_WAIT: begin
                    o_stall_if  = 1'b1;
                    o_stall_dec = 1'b1;
                    o_stall_ex  = 1'b1;
                    o_stall_mem = 1'b1;
                end
                REDIRECT: begin
                    o_flush_dec = 1'b1;
                    o_flush_ex  = 1'b1;
                end
                LW_BUBBLE: begin
                    o_stall_if  = 1'b1;
                    o_stall_dec = 1'b1;
                    o_flush_ex  = 1'b1;
                end
                IC_WAIT: begin
                    o_stall_if  = 1'b1;
                    o_flush_dec = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Watchdog is a down-counter of remaining wait cycles; reaching zero on a
    // served wait is the terminal count. Any non-wait cause reloads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            o_stall_cycles <= '0;
            o_bubble_count <= '0;
            wait_left      <= WAIT_LOAD;
            o_timeout      <= 1'b0;
        end else begin
            state_q <= cause;
            if (o_stall_if && (o_stall_cycles != '1))
                o_stall_cycles <= o_stall_cycles + 1'b1;
            if ((o_flush_dec || o_flush_ex) && (o_bubble_count != '1))
                o_bubble_count <= o_bubble_count + 1'b1;
            if (is_wait) begin
                if (wait_left == '0)
                    o_timeout <= 1'b1;
                else
                    wait_left <= wait_left - 1'b1;
            end else begin
                wait_left <= WAIT_LOAD;
            end
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    logic clk = 1'b0;
    logic rst;
    logic lw, ic, dc, mp;

    logic        s_if, s_dec, s_ex, s_mem, f_dec, f_ex;
    logic [2:0]  state;
    logic [31:0] stall_cnt, bub_cnt;
    logic        tmo;

    logic        t_if, t_dec, t_ex, t_mem, tf_dec, tf_ex;
    logic [2:0]  t_state;
    logic [3:0]  t_stall, t_bub;
    logic        t_tmo;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_controller #(.CNT_WIDTH(32), .MISS_TIMEOUT(256)) dut (
        .clk(clk), .rst(rst),
        .i_lw_hazard(lw), .i_ic_miss(ic), .i_dc_miss(dc), .i_mispredict(mp),
        .o_stall_if(s_if), .o_stall_dec(s_dec), .o_stall_ex(s_ex), .o_stall_mem(s_mem),
        .o_flush_dec(f_dec), .o_flush_ex(f_ex), .o_state(state),
        .o_stall_cycles(stall_cnt), .o_bubble_count(bub_cnt), .o_timeout(tmo)
    );

    hazard_controller #(.CNT_WIDTH(4), .MISS_TIMEOUT(256)) dut_sat (
        .clk(clk), .rst(rst),
        .i_lw_hazard(lw), .i_ic_miss(ic), .i_dc_miss(dc), .i_mispredict(mp),
        .o_stall_if(t_if), .o_stall_dec(t_dec), .o_stall_ex(t_ex), .o_stall_mem(t_mem),
        .o_flush_dec(tf_dec), .o_flush_ex(tf_ex), .o_state(t_state),
        .o_stall_cycles(t_stall), .o_bubble_count(t_bub), .o_timeout(t_tmo)
    );

    // {stall_if, stall_dec, stall_ex, stall_mem, flush_dec, flush_ex}
    logic [5:0] outs;
    assign outs = {s_if, s_dec, s_ex, s_mem, f_dec, f_ex};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic l, input logic i, input logic d, input logic m);
        lw = l; ic = i; dc = d; mp = m;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        lw = 1'b0; ic = 1'b0; dc = 1'b0; mp = 1'b0;
        tick();

        // reset with unknown inputs: drain flushes only
        set_in(1'bx, 1'bx, 1'bx, 1'bx);
        check("rst_outs", outs, 6'b000011);
        tick();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_state", state, 3'd0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_bub_cnt", bub_cnt, 0);
        check("rst_timeout", tmo, 1'b0);
        check("run_outs", outs, 6'b000000);

        // single load-use cycle
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        check("lw_outs", outs, 6'b110001);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check("lw_state", state, 3'd3);
        check("lw_bub_cnt", bub_cnt, 1);
        check("lw_stall_cnt", stall_cnt, 1);
        check("lw_after_outs", outs, 6'b000000);

        // D-miss 5 cycles, mispredict cycles 2-6
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            set_in(1'b0, 1'b0, 1'b1, (c >= 2));
            check($sformatf("dmiss_outs_c%0d", c), outs, 6'b111100);
            if (c == 2) check("dmiss_state", state, 3'd1);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        check("dmiss_redirect_outs", outs, 6'b000011);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check("dmiss_redirect_state", state, 3'd2);
        check("dmiss_stall_cnt", stall_cnt, 5);
        check("dmiss_bub_cnt", bub_cnt, 1);
        check("dmiss_no_timeout", tmo, 1'b0);

        // mispredict beats I-miss and lw
        set_in(1'b1, 1'b1, 1'b0, 1'b1);
        check("mp_ic_outs", outs, 6'b000011);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check("mp_ic_state", state, 3'd2);

        // lw beats I-miss
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        check("lw_ic_outs", outs, 6'b110001);
        tick();
        // I-miss alone
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        check("lw_ic_state", state, 3'd3);
        check("ic_outs", outs, 6'b100010);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check("ic_state", state, 3'd4);

        // watchdog: 255 waits then RUN stays clear
        do_reset();
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 255; c++) tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check("wd_255_timeout", tmo, 1'b0);
        tick();
        check("wd_run_timeout", tmo, 1'b0);
        // 256 consecutive waits trip it on the 256th edge
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 255; c++) tick();
        check("wd_pre_trip", tmo, 1'b0);
        tick();
        check("wd_trip", tmo, 1'b1);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("wd_sticky", tmo, 1'b1);
        check("wd_stall_cnt", stall_cnt, 511);
        check("wd_sat_stall_cnt", t_stall, 4'hF);
        do_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check("wd_cleared", tmo, 1'b0);

        // saturation: 20 stall cycles on the 4-bit instance
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 20; c++) tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_stall_cnt", t_stall, 4'hF);
        check("wide_stall_cnt", stall_cnt, 20);
        // mixed-cause waits also count toward the watchdog but 20 is far below
        check("sat_no_timeout", tmo, 1'b0);

        // reset mid-D-miss
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        check("midrst_outs", outs, 6'b000011);
        tick();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst_state", state, 3'd0);
        check("midrst_stall_cnt", stall_cnt, 0);
        check("midrst_bub_cnt", bub_cnt, 0);
        check("midrst_outs_after", outs, 6'b000000);
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        check("midrst_new_miss", outs, 6'b111100);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst_new_state", state, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
